mem_io_ctrl: RTL and testbench

MEM_IO_CTRL -- requirements
Module: mem_io_ctrl

---
 rtl/mem_io_ctrl_pkg.sv | 18 +
 rtl/mem_io_ctrl_if.sv | 27 ++
 rtl/mem_io_ctrl_byte_fifo.sv | 56 +++++
 rtl/mem_io_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_io_ctrl.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_io_ctrl_pkg.sv
// rtl/mem_io_ctrl_pkg.sv - shared address map constants and types for mem_io_ctrl
package mem_io_ctrl_pkg;

    localparam logic [1:0]  IO_SPACE_SEL  = 2'b11;
    localparam logic [17:0] IO_UART_ADDR  = 18'h30000;
    localparam logic [17:0] IO_CYCLE_ADDR = 18'h30004;

    // Which registered source drives mem_din in the cycle after an access
    typedef enum logic {
        SRC_IO  = 1'b0,
        SRC_RAM = 1'b1
    } rd_src_e;

    function automatic logic is_io(input logic [17:0] addr);
        return addr[17:16] == IO_SPACE_SEL;
    endfunction

endpackage

// File: rtl/mem_io_ctrl_if.sv
// rtl/mem_io_ctrl_if.sv - CPU bus and UART handshake bundle for mem_io_ctrl
interface mem_io_ctrl_if;

    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_pop;
    logic        program_done;

    modport master (
        output mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
        input  mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, program_done
    );

    modport slave (
        input  mem_a, mem_dout, mem_wr, tx_ready, rx_data, rx_valid,
        output mem_din, io_buffer_full, tx_data, tx_valid, rx_pop, program_done
    );

endinterface

// File: rtl/mem_io_ctrl_byte_fifo.sv
// rtl/mem_io_ctrl_byte_fifo.sv - byte-wide UART transmit FIFO
module byte_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic [7:0]               din,
    input  logic                     pop,
    output logic [7:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    // a push into a full FIFO is dropped even if a pop happens the same cycle
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // storage array, no reset so it maps onto plain registers or LUT RAM
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mem_io_ctrl.sv
// rtl/mem_io_ctrl.sv - CPU byte bus to RAM, UART and cycle-counter IO
module mem_io_ctrl
    import mem_io_ctrl_pkg::*;
#(
    parameter int RAM_AW   = 17,
    parameter int TX_DEPTH = 8
) (
    input logic          clk_in,
    input logic          rst_in,
    mem_io_ctrl_if.slave bus
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    logic [17:0]       addr;
    logic              io_sel;
    logic              io_rd;
    logic              unused_addr_bits;

    logic [7:0]        ram [2**RAM_AW];
    logic [7:0]        ram_q;
    logic              ram_wr;

    logic              fifo_push;
    logic [7:0]        fifo_din;
    logic              fifo_pop;
    logic [7:0]        fifo_dout;
    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic [CW-1:0]     count_next;

    logic [31:0]       cycle_cnt;
    logic [31:0]       snapshot;
    logic [7:0]        io_next;
    logic [7:0]        io_q;
    rd_src_e           rd_src;
    logic              done_q;
    logic              buf_full_q;

    assign addr             = bus.mem_a[17:0];
    assign unused_addr_bits = ^bus.mem_a[31:18];
    assign io_sel           = is_io(addr);
    assign io_rd            = io_sel && !bus.mem_wr;

    // every access is gated by rst_in so a cycle caught by reset has no side effect
    assign ram_wr    = rst_in && bus.mem_wr && !io_sel;
    assign fifo_push = rst_in && io_sel && bus.mem_wr &&
                       ((addr == IO_UART_ADDR && bus.mem_dout != 8'h00) ||
                        addr == IO_CYCLE_ADDR);
    assign fifo_din  = (addr == IO_CYCLE_ADDR) ? 8'h00 : bus.mem_dout;
    assign fifo_pop  = !fifo_empty && bus.tx_ready;

    // mirror of the FIFO's next occupancy so the back-pressure flag is timely
    assign count_next = fifo_count + CW'(fifo_push && !fifo_full) - CW'(fifo_pop);

    assign bus.tx_valid       = !fifo_empty;
    assign bus.tx_data        = fifo_dout;
    assign bus.rx_pop         = rst_in && io_rd && addr == IO_UART_ADDR && bus.rx_valid;
    assign bus.mem_din        = (rd_src == SRC_RAM) ? ram_q : io_q;
    assign bus.program_done   = done_q;
    assign bus.io_buffer_full = buf_full_q;

    byte_fifo #(
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .push   (fifo_push),
        .din    (fifo_din),
        .pop    (fifo_pop),
        .dout   (fifo_dout),
        .count  (fifo_count),
        .empty  (fifo_empty),
        .full   (fifo_full)
    );

    // synchronous-read RAM; reads and writes never share a cycle so no bypass is needed
    always_ff @(posedge clk_in) begin
        if (ram_wr) begin
            ram[bus.mem_a[RAM_AW-1:0]] <= bus.mem_dout;
        end
        ram_q <= ram[bus.mem_a[RAM_AW-1:0]];
    end

    // IO read data: UART receive byte, live counter low byte, or snapshot upper bytes
    always_comb begin
        io_next = 8'h00;
        if (io_rd) begin
            case (addr)
                IO_UART_ADDR:          io_next = bus.rx_valid ? bus.rx_data : 8'h00;
                IO_CYCLE_ADDR:         io_next = cycle_cnt[7:0];
                IO_CYCLE_ADDR + 18'd1: io_next = snapshot[15:8];
                IO_CYCLE_ADDR + 18'd2: io_next = snapshot[23:16];
                IO_CYCLE_ADDR + 18'd3: io_next = snapshot[31:24];
                default:               io_next = 8'h00;
            endcase
        end
    end

    // free-running cycle counter and the snapshot taken by a low-byte read
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cycle_cnt <= '0;
            snapshot  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (io_rd && addr == IO_CYCLE_ADDR) begin
                snapshot <= cycle_cnt;
            end
        end
    end

    // registered read path selection and IO read data
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            io_q   <= 8'h00;
            rd_src <= SRC_IO;
        end else begin
            io_q   <= io_next;
            rd_src <= (!bus.mem_wr && !io_sel) ? SRC_RAM : SRC_IO;
        end
    end

    // sticky stop flag and registered UART back-pressure
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            done_q     <= 1'b0;
            buf_full_q <= 1'b0;
        end else begin
            if (fifo_push && addr == IO_CYCLE_ADDR) begin
                done_q <= 1'b1;
            end
            buf_full_q <= (count_next >= CW'(TX_DEPTH - 1));
        end
    end

endmodule

// File: tb/tb_mem_io_ctrl.sv
// tb/tb_mem_io_ctrl.sv - self-checking bench for mem_io_ctrl
module tb_mem_io_ctrl;

    logic clk_in = 1'b0;
    logic rst_in = 1'b0;

    always #5 clk_in = ~clk_in;

    mem_io_ctrl_if bus ();

    mem_io_ctrl #(
        .RAM_AW   (17),
        .TX_DEPTH (8)
    ) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic        rxv;
        logic [7:0]  rxd;
        logic        chk;
        logic [7:0]  din;
        logic        pop;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  txq [$];
    vec_t        vt [$];

    // reference model state for the randomized run
    logic [31:0] m_cnt;
    logic [31:0] m_snap;
    logic        m_done;
    logic [7:0]  m_fifo [$];
    logic [7:0]  m_ram [int];

    // record every byte the UART accepts
    always @(negedge clk_in) begin
        if (rst_in && bus.tx_valid && bus.tx_ready) txq.push_back(bus.tx_data);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic wr, input logic [31:0] a, input logic [7:0] d,
                         input logic rxv, input logic [7:0] rxd, input logic rdy);
        bus.mem_wr   = wr;
        bus.mem_a    = a;
        bus.mem_dout = d;
        bus.rx_valid = rxv;
        bus.rx_data  = rxd;
        bus.tx_ready = rdy;
    endtask

    task automatic tick;
        @(posedge clk_in);
        #1;
    endtask

    task automatic idle(input logic rdy);
        drive(1'b0, 32'h0, 8'h00, 1'b0, 8'h00, rdy);
    endtask

    task automatic do_reset;
        idle(1'b0);
        rst_in = 1'b0;
        tick();
        tick();
        rst_in = 1'b1;
    endtask

    function automatic vec_t mk(input logic wr, input logic [31:0] a, input logic [7:0] d,
                                input logic rxv, input logic [7:0] rxd,
                                input logic chk, input logic [7:0] din, input logic pop);
        vec_t v;
        v.wr = wr; v.a = a; v.d = d; v.rxv = rxv; v.rxd = rxd;
        v.chk = chk; v.din = din; v.pop = pop;
        return v;
    endfunction

    task automatic run_random(input int cycles);
        logic        wr, rxv, rdy, io, exp_pop, known, full_before;
        logic [31:0] a, rnd;
        logic [7:0]  d, rxd, exp_din;
        logic [1:0]  hi;
        logic [17:0] off;
        int          idx;
        do_reset();
        m_cnt = 32'd0; m_snap = 32'd0; m_done = 1'b0;
        m_fifo.delete();
        m_ram.delete();
        for (int n = 0; n < cycles; n++) begin
            rnd = $urandom();
            wr  = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) begin
                hi = 2'($urandom_range(0, 2));
                a  = {rnd[31:18], hi, 13'h0, rnd[2:0]};
            end else begin
                off = ($urandom_range(0, 1) == 0) ? 18'h30000 : 18'h30000 + 18'($urandom_range(0, 9));
                a   = {rnd[31:18], off};
            end
            d   = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom());
            rxv = 1'($urandom_range(0, 1));
            rxd = 8'($urandom());
            rdy = ((n % 300) < 120) ? 1'b0 : 1'($urandom_range(0, 1));
            drive(wr, a, d, rxv, rxd, rdy);

            io      = (a[17:16] == 2'b11);
            off     = a[17:0];
            idx     = int'(a[16:0]);
            exp_pop = io && !wr && off == 18'h30000 && rxv;

            @(negedge clk_in);
            check("rnd_rx_pop", 32'(bus.rx_pop), 32'(exp_pop));
            check("rnd_tx_valid", 32'(bus.tx_valid), 32'(m_fifo.size() != 0));
            if (m_fifo.size() != 0) check("rnd_tx_data", 32'(bus.tx_data), 32'(m_fifo[0]));

            full_before = (m_fifo.size() == 8);
            if (m_fifo.size() != 0 && rdy) void'(m_fifo.pop_front());
            if (io && wr && !full_before) begin
                if (off == 18'h30000 && d != 8'h00) m_fifo.push_back(d);
                if (off == 18'h30004) m_fifo.push_back(8'h00);
            end
            if (io && wr && off == 18'h30004) m_done = 1'b1;

            known   = 1'b0;
            exp_din = 8'h00;
            if (!wr && !io) begin
                if (m_ram.exists(idx)) begin
                    known   = 1'b1;
                    exp_din = m_ram[idx];
                end
            end else if (!wr) begin
                known = 1'b1;
                case (off)
                    18'h30000: exp_din = rxv ? rxd : 8'h00;
                    18'h30004: begin exp_din = m_cnt[7:0]; m_snap = m_cnt; end
                    18'h30005: exp_din = m_snap[15:8];
                    18'h30006: exp_din = m_snap[23:16];
                    18'h30007: exp_din = m_snap[31:24];
                    default:   exp_din = 8'h00;
                endcase
            end else if (!io) begin
                m_ram[idx] = d;
            end
            m_cnt = m_cnt + 32'd1;

            @(posedge clk_in);
            #1;
            if (known) check("rnd_mem_din", 32'(bus.mem_din), 32'(exp_din));
            check("rnd_io_buffer_full", 32'(bus.io_buffer_full), 32'(m_fifo.size() >= 7));
            check("rnd_program_done", 32'(bus.program_done), 32'(m_done));
        end
    endtask

    initial begin
        logic [31:0] v;

        // reset state, with an access that must be discarded
        drive(1'b1, 32'h30004, 8'h11, 1'b1, 8'h5A, 1'b1);
        rst_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        check("rst_mem_din", 32'(bus.mem_din), 32'h0);
        check("rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("rst_program_done", 32'(bus.program_done), 32'h0);
        check("rst_io_buffer_full", 32'(bus.io_buffer_full), 32'h0);
        drive(1'b0, 32'h30000, 8'h00, 1'b1, 8'h5A, 1'b1);
        @(negedge clk_in);
        check("rst_rx_pop", 32'(bus.rx_pop), 32'h0);
        tick();
        idle(1'b0);
        rst_in = 1'b1;
        tick();
        check("post_rst_program_done", 32'(bus.program_done), 32'h0);
        check("post_rst_tx_valid", 32'(bus.tx_valid), 32'h0);

        // table: RAM, decode and UART receive
        vt.push_back(mk(1'b1, 32'h0001_0010, 8'hA5, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        vt.push_back(mk(1'b0, 32'h0001_0010, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0));
        vt.push_back(mk(1'b1, 32'h0000_0010, 8'h3E, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        vt.push_back(mk(1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3E, 1'b0));
        vt.push_back(mk(1'b1, 32'h0001_FFFF, 8'h5A, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        vt.push_back(mk(1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 8'h00, 1'b1, 8'h5A, 1'b0));
        vt.push_back(mk(1'b1, 32'h0000_0020, 8'h77, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        vt.push_back(mk(1'b0, 32'h0000_0020, 8'h00, 1'b0, 8'h00, 1'b1, 8'h77, 1'b0));
        vt.push_back(mk(1'b0, 32'h0002_0010, 8'h00, 1'b0, 8'h00, 1'b1, 8'h3E, 1'b0));
        vt.push_back(mk(1'b0, 32'hFFFD_0010, 8'h00, 1'b0, 8'h00, 1'b1, 8'hA5, 1'b0));
        vt.push_back(mk(1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h3C, 1'b1, 8'h3C, 1'b1));
        vt.push_back(mk(1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'h3C, 1'b1, 8'h00, 1'b0));
        vt.push_back(mk(1'b0, 32'hABCF_0000, 8'h00, 1'b1, 8'hC3, 1'b1, 8'hC3, 1'b1));
        vt.push_back(mk(1'b0, 32'h0003_0008, 8'h00, 1'b1, 8'h99, 1'b1, 8'h00, 1'b0));
        vt.push_back(mk(1'b0, 32'h0003_0001, 8'h00, 1'b1, 8'h99, 1'b1, 8'h00, 1'b0));
        vt.push_back(mk(1'b1, 32'h0003_0000, 8'h00, 1'b1, 8'h99, 1'b0, 8'h00, 1'b0));
        vt.push_back(mk(1'b1, 32'h0003_0002, 8'h55, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0));
        for (int i = 0; i < vt.size(); i++) begin
            drive(vt[i].wr, vt[i].a, vt[i].d, vt[i].rxv, vt[i].rxd, 1'b0);
            @(negedge clk_in);
            check($sformatf("vec%0d_rx_pop", i), 32'(bus.rx_pop), 32'(vt[i].pop));
            tick();
            if (vt[i].chk) check($sformatf("vec%0d_mem_din", i), 32'(bus.mem_din), 32'(vt[i].din));
        end
        check("vec_no_push", 32'(bus.tx_valid), 32'h0);

        // RAM keeps contents across reset; write during reset is discarded
        drive(1'b1, 32'h0000_0010, 8'hFF, 1'b0, 8'h00, 1'b0);
        rst_in = 1'b0;
        tick();
        tick();
        idle(1'b0);
        rst_in = 1'b1;
        drive(1'b0, 32'h0000_0010, 8'h00, 1'b0, 8'h00, 1'b0);
        tick();
        check("ram_survives_reset", 32'(bus.mem_din), 32'h3E);

        // 'H', 0x00, 'i' transmit only H and i
        txq.delete();
        drive(1'b1, 32'h30000, 8'h48, 1'b0, 8'h00, 1'b1); tick();
        drive(1'b1, 32'h30000, 8'h00, 1'b0, 8'h00, 1'b1); tick();
        drive(1'b1, 32'h30000, 8'h69, 1'b0, 8'h00, 1'b1); tick();
        idle(1'b1);
        repeat (3) tick();
        check("hi_count", 32'(txq.size()), 32'd2);
        if (txq.size() == 2) begin
            check("hi_byte0", 32'(txq[0]), 32'h48);
            check("hi_byte1", 32'(txq[1]), 32'h69);
        end

        // fill with tx_ready low: flag at 7, 8th accepted, 9th dropped
        txq.delete();
        for (int i = 1; i <= 9; i++) begin
            drive(1'b1, 32'h30000, 8'(i), 1'b0, 8'h00, 1'b0);
            tick();
            if (i == 6) check("full_after_6", 32'(bus.io_buffer_full), 32'h0);
            if (i == 7) check("full_after_7", 32'(bus.io_buffer_full), 32'h1);
        end
        idle(1'b1);
        repeat (12) tick();
        check("drain_count", 32'(txq.size()), 32'd8);
        for (int i = 0; i < txq.size() && i < 8; i++) begin
            check($sformatf("drain_byte%0d", i), 32'(txq[i]), 32'(i + 1));
        end
        check("drain_empty", 32'(bus.tx_valid), 32'h0);
        check("drain_flag_clear", 32'(bus.io_buffer_full), 32'h0);

        // program stop: 0x00 sent, sticky flag, reset mid-drain clears all
        txq.delete();
        drive(1'b1, 32'h30004, 8'h99, 1'b0, 8'h00, 1'b1); tick();
        check("stop_done_set", 32'(bus.program_done), 32'h1);
        idle(1'b1);
        tick();
        tick();
        check("stop_tx_count", 32'(txq.size()), 32'd1);
        if (txq.size() == 1) check("stop_tx_zero", 32'(txq[0]), 32'h00);
        drive(1'b1, 32'h30000, 8'h41, 1'b0, 8'h00, 1'b0); tick();
        drive(1'b1, 32'h30000, 8'h42, 1'b0, 8'h00, 1'b0); tick();
        check("stop_done_sticky", 32'(bus.program_done), 32'h1);
        idle(1'b1);
        tick();
        check("mid_drain_valid", 32'(bus.tx_valid), 32'h1);
        rst_in = 1'b0;
        #1;
        check("mid_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("mid_rst_done", 32'(bus.program_done), 32'h0);
        tick();
        rst_in = 1'b1;
        tick();
        check("after_rst_tx_valid", 32'(bus.tx_valid), 32'h0);
        check("after_rst_done", 32'(bus.program_done), 32'h0);

        // cycle counter read at cycle 100 after reset release
        do_reset();
        repeat (100) tick();
        v = 32'h0;
        for (int b = 0; b < 4; b++) begin
            drive(1'b0, 32'h30004 + 32'(b), 8'h00, 1'b0, 8'h00, 1'b0);
            tick();
            v[8*b +: 8] = bus.mem_din;
        end
        check("cycle_at_100", 32'(v >= 32'd99 && v <= 32'd101), 32'h1);
        check("cycle_upper_zero", {8'h0, v[31:8]}, 32'h0);

        run_random(1500);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
